// File: rtl/counter_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_bist_ctrl
// Purpose  : BIST sequencer/checker for an up counter. Drives reset/enable into
//            the counter and compares count_in against a reference model.
// Option   : COUNTER_BIST_ERRLOG_EN enables the first-mismatch error log.
// Revision : 1.0 - initial release
// ============================================================================
module counter_bist_ctrl #(
  parameter int WIDTH       = 4,
  parameter int RUN_CYCLES  = 5,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count_in,
  output logic             dut_reset,
  output logic             dut_enable,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [15:0]      err_cycle,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_got
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST = 8'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  state_t           state_q;
  logic [15:0]      run_cnt_q;
  logic [7:0]       hold_cnt_q;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             dut_reset_q, dut_enable_q, busy_q, done_q, pass_q;

  logic cmp_active;
  logic mismatch;
  logic start_accept;

  assign cmp_active   = (state_q == S_RUN) || (state_q == S_HOLD) || (state_q == S_CHK);
  assign mismatch     = cmp_active && (count_in != expected_q);
  assign start_accept = (state_q == S_IDLE) && start;

  // Model follows the registered drive, giving the counter's one-cycle latency.
  always_comb begin
    expected_d = expected_q;
    if (dut_reset_q) begin
      expected_d = '0;
    end else if (dut_enable_q) begin
      expected_d = expected_q + 1'b1;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (start_accept) begin
      err_count_d = 8'd0;
    end else if (mismatch && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      run_cnt_q    <= 16'd0;
      hold_cnt_q   <= 8'd0;
      expected_q   <= '0;
      err_count_q  <= 8'd0;
      dut_reset_q  <= 1'b0;
      dut_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RST;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
          end
        end
        S_RST: begin
          state_q      <= S_RUN;
          dut_reset_q  <= 1'b0;
          dut_enable_q <= 1'b1;
          run_cnt_q    <= 16'd0;
        end
        S_RUN: begin
          if (run_cnt_q == RUN_LAST) begin
            dut_enable_q <= 1'b0;
            hold_cnt_q   <= 8'd0;
            if (HOLD_CYCLES == 0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_HOLD;
            end
          end else begin
            run_cnt_q <= run_cnt_q + 16'd1;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= S_CHK;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        S_CHK: begin
          // Verdict must include this cycle's compare, not yet in err_count_q.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_count_q == 8'd0) && !mismatch;
        end
        default: begin
          state_q      <= S_IDLE;
          dut_reset_q  <= 1'b0;
          dut_enable_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign dut_reset  = dut_reset_q;
  assign dut_enable = dut_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;

`ifdef COUNTER_BIST_ERRLOG_EN
  logic [15:0]      chk_idx_q;
  logic [15:0]      err_cycle_q;
  logic [WIDTH-1:0] err_expected_q;
  logic [WIDTH-1:0] err_got_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_idx_q      <= 16'd0;
      err_cycle_q    <= 16'd0;
      err_expected_q <= '0;
      err_got_q      <= '0;
    end else if (start_accept) begin
      chk_idx_q      <= 16'd0;
      err_cycle_q    <= 16'd0;
      err_expected_q <= '0;
      err_got_q      <= '0;
    end else if (cmp_active) begin
      chk_idx_q <= chk_idx_q + 16'd1;
      if (mismatch && (err_count_q == 8'd0)) begin
        err_cycle_q    <= chk_idx_q;
        err_expected_q <= expected_q;
        err_got_q      <= count_in;
      end
    end
  end

  assign err_cycle    = err_cycle_q;
  assign err_expected = err_expected_q;
  assign err_got      = err_got_q;
`else
  assign err_cycle    = 16'd0;
  assign err_expected = '0;
  assign err_got      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_bist_ctrl.sv
`default_nettype none
// Testbench for counter_bist_ctrl: behavioural counters with injectable faults
// feed two controllers; a scoreboard checks each done against queued results.
module tb_counter_bist_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b;
  int   mode_a;  // 0 good, 1 bit0 stuck at 0, 3 counts while disabled

  always #5 clk = ~clk;

  logic        a_dut_reset, a_dut_enable, a_busy, a_done, a_pass;
  logic [7:0]  a_err_count;
  logic [15:0] a_err_cycle;
  logic [3:0]  a_err_expected, a_err_got, a_count, cnt_a_q;

  logic        b_dut_reset, b_dut_enable, b_busy, b_done, b_pass;
  logic [7:0]  b_err_count;
  logic [15:0] b_err_cycle;
  logic [3:0]  b_err_expected, b_err_got, cnt_b_q;

  counter_bist_ctrl #(.WIDTH(4), .RUN_CYCLES(5), .HOLD_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .count_in(a_count),
    .dut_reset(a_dut_reset), .dut_enable(a_dut_enable), .busy(a_busy),
    .done(a_done), .pass(a_pass), .err_count(a_err_count),
    .err_cycle(a_err_cycle), .err_expected(a_err_expected), .err_got(a_err_got)
  );

  counter_bist_ctrl #(.WIDTH(4), .RUN_CYCLES(20), .HOLD_CYCLES(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .count_in(cnt_b_q),
    .dut_reset(b_dut_reset), .dut_enable(b_dut_enable), .busy(b_busy),
    .done(b_done), .pass(b_pass), .err_count(b_err_count),
    .err_cycle(b_err_cycle), .err_expected(b_err_expected), .err_got(b_err_got)
  );

  always @(posedge clk) begin
    if (a_dut_reset) cnt_a_q <= 4'd0;
    else if (a_dut_enable || mode_a == 3) cnt_a_q <= cnt_a_q + 4'd1;
  end
  assign a_count = (mode_a == 1) ? {cnt_a_q[3:1], 1'b0} : cnt_a_q;

  // Faulty counter that saturates at 15 instead of wrapping.
  always @(posedge clk) begin
    if (b_dut_reset) cnt_b_q <= 4'd0;
    else if (b_dut_enable && cnt_b_q != 4'd15) cnt_b_q <= cnt_b_q + 4'd1;
  end

  typedef struct {
    int pass;
    int errs;
    int cyc;
    int ev;
    int gv;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int p, input int e, input int c, input int ev, input int gv);
    exp_t r;
    r.pass = p;
    r.errs = e;
`ifdef COUNTER_BIST_ERRLOG_EN
    r.cyc = c;
    r.ev  = ev;
    r.gv  = gv;
`else
    r.cyc = 0 * c;
    r.ev  = 0 * ev;
    r.gv  = 0 * gv;
`endif
    return r;
  endfunction

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (a_done) begin
        chk("a_done_pending", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_pass", int'(a_pass), e.pass);
          chk("a_err_count", int'(a_err_count), e.errs);
          chk("a_err_cycle", int'(a_err_cycle), e.cyc);
          chk("a_err_expected", int'(a_err_expected), e.ev);
          chk("a_err_got", int'(a_err_got), e.gv);
        end
      end
      if (b_done) begin
        chk("b_done_pending", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_pass", int'(b_pass), e.pass);
          chk("b_err_count", int'(b_err_count), e.errs);
          chk("b_err_cycle", int'(b_err_cycle), e.cyc);
          chk("b_err_expected", int'(b_err_expected), e.ev);
          chk("b_err_got", int'(b_err_got), e.gv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string name);
    for (int k = 0; k < 100 && !a_done; k++) tick();
    chk({name, "_done_seen"}, int'(a_done), 1);
    tick();
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic check_a_zero(input string name);
    chk({name, "_dut_reset"}, int'(a_dut_reset), 0);
    chk({name, "_dut_enable"}, int'(a_dut_enable), 0);
    chk({name, "_busy"}, int'(a_busy), 0);
    chk({name, "_done"}, int'(a_done), 0);
    chk({name, "_pass"}, int'(a_pass), 0);
    chk({name, "_err_count"}, int'(a_err_count), 0);
    chk({name, "_err_cycle"}, int'(a_err_cycle), 0);
    chk({name, "_err_expected"}, int'(a_err_expected), 0);
    chk({name, "_err_got"}, int'(a_err_got), 0);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    tick(); tick(); tick();
    check_a_zero("reset");
    chk("reset_b_busy", int'(b_busy), 0);
    reset = 1'b0;
    tick();

    // Good counter: drive waveform and done latency
    qa.push_back(mk(1, 0, 0, 0, 0));
    pulse_a();
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("seq_rst_k%0d", k), int'(a_dut_reset), int'(k == 1));
      chk($sformatf("seq_en_k%0d", k), int'(a_dut_enable), int'(k >= 2 && k <= 6));
      chk($sformatf("seq_busy_k%0d", k), int'(a_busy), int'(k <= 9));
      chk($sformatf("seq_done_k%0d", k), int'(a_done), int'(k == 10));
      tick();
    end

    // Bit0 stuck at 0: first mismatch at index 1 (expected 1, got 0), 5 total
    mode_a = 1;
    qa.push_back(mk(0, 5, 1, 1, 0));
    pulse_a();
    wait_done_a("stuck");

    // Counts while disabled: HOLD2 and CHK mismatch (expected 5, got 6 first)
    mode_a = 3;
    qa.push_back(mk(0, 2, 6, 5, 6));
    pulse_a();
    wait_done_a("runaway");

    // start pulsed during RUN is ignored
    mode_a = 0;
    qa.push_back(mk(1, 0, 0, 0, 0));
    pulse_a();
    tick(); tick();
    chk("restart_in_run_en", int'(a_dut_enable), 1);
    pulse_a();
    wait_done_a("restart");
    for (int k = 0; k < 12; k++) begin
      chk("restart_no_second_done", int'(a_done), 0);
      tick();
    end

    // Reset during the third RUN cycle aborts without done
    pulse_a();
    tick(); tick(); tick();
    chk("abort_in_run", int'(a_dut_enable), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_a_zero("abort");
    for (int k = 0; k < 12; k++) begin
      chk("abort_no_done", int'(a_done), 0);
      tick();
    end
    qa.push_back(mk(1, 0, 0, 0, 0));
    pulse_a();
    wait_done_a("after_abort");

    // start held across done: back-to-back tests
    qa.push_back(mk(1, 0, 0, 0, 0));
    qa.push_back(mk(1, 0, 0, 0, 0));
    start_a = 1'b1;
    for (int k = 0; k < 100 && !a_done; k++) tick();
    chk("held_done_seen", int'(a_done), 1);
    tick();
    chk("held_restart_busy", int'(a_busy), 1);
    chk("held_restart_pass", int'(a_pass), 0);
    chk("held_restart_rst", int'(a_dut_reset), 1);
    start_a = 1'b0;
    wait_done_a("held_second");

    // Saturating counter over a 20-cycle run: first miss at index 16, 7 total
    qb.push_back(mk(0, 7, 16, 0, 15));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 100 && !b_done; k++) tick();
    chk("b_done_seen", int'(b_done), 1);
    tick(); tick();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
